// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner (key_col_scanner, key_scan_4x4).
package key_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t DEB     = 2'd1;
  localparam state_t PRESSED = 2'd2;
  localparam state_t REL     = 2'd3;

  // Snapshot bit index is col*NUM_ROWS+row; the reported code is row*NUM_COLS+col.
  function automatic logic [3:0] encode_key(input logic [NUM_KEYS-1:0] onehot);
    logic [3:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) code = 4'((i % NUM_ROWS) * NUM_COLS + (i / NUM_ROWS));
    end
    return code;
  endfunction

endpackage

// File: rtl/key_scan_4x4_scanner.sv
// Column walker for the keypad: drives one column low per slot, synchronizes the rows
// and assembles a full-scan snapshot, flagging scan_end after the last column is sampled.
module key_col_scanner
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV = 24000
) (
  input  logic                clk_24m,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] key_row,
  output logic [NUM_COLS-1:0] key_col,
  output logic [NUM_KEYS-1:0] snapshot,
  output logic                scan_end
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

  logic [SLOT_W-1:0]   slot;
  logic [COL_W-1:0]    col;
  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;

  assign key_col = ~(NUM_COLS'(1) << col);

  // Rows are sampled on the last slot cycle, long after the column settled and the
  // two-stage synchronizer caught up.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      col      <= '0;
      row_meta <= '1;
      row_sync <= '1;
      snapshot <= '0;
      scan_end <= 1'b0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
      scan_end <= 1'b0;
      if (slot == SLOT_LAST) begin
        slot <= '0;
        col  <= col + COL_W'(1);
        snapshot[col*NUM_ROWS +: NUM_ROWS] <= ~row_sync;
        scan_end <= (col == COL_LAST);
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_scan_4x4.sv
// 4x4 keypad scanner top: debounces single-key snapshots over full scans and reports codes.
// Optional auto-repeat while a key is held is enabled by defining KEY_SCAN_REPEAT_EN.
module key_scan_4x4
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV      = 24000,
  parameter int DEB_SCANS     = 5,
  parameter int REPEAT_DELAY  = 125,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_SCANS);

  if (DEB_SCANS < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("key_scan_4x4: DEB_SCANS must be >= 2 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  logic [NUM_KEYS-1:0] snapshot;
  logic [NUM_KEYS-1:0] cand;
  logic                scan_end;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                snap_empty;
  logic                snap_single;
  logic                accept_fire;
  logic                rep_fire;

  key_col_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk_24m  (clk_24m),
    .rst_n    (rst_n),
    .key_row  (key_row),
    .key_col  (key_col),
    .snapshot (snapshot),
    .scan_end (scan_end)
  );

  assign cnt_inc     = cnt + CNT_ONE;
  assign snap_empty  = (snapshot == '0);
  assign snap_single = $onehot(snapshot);
  assign accept_fire = scan_end && (state == DEB) && (snapshot == cand) && (cnt_inc == CNT_LAST);

`ifdef KEY_SCAN_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_inc;
  logic             rep_hit;

  assign rep_inc  = rep_cnt + REP_ONE;
  assign rep_hit  = (rep_inc == REP_LAST);
  assign rep_fire = scan_end && (state == PRESSED) && !snap_empty && rep_hit;

  // The key counts as held through REL, so the count only clears once release is accepted.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (scan_end) begin
      if ((state == PRESSED || state == REL) &&
          !(state == REL && snap_empty && cnt_inc == CNT_LAST)) begin
        rep_cnt <= rep_hit ? REP_RELOAD : rep_inc;
      end else begin
        rep_cnt <= '0;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= accept_fire || rep_fire;
      if (scan_end) begin
        case (state)
          IDLE: begin
            if (snap_single) begin
              state <= DEB;
              cand  <= snapshot;
              cnt   <= CNT_ONE;
            end
          end
          DEB: begin
            if (accept_fire) begin
              state       <= PRESSED;
              cnt         <= '0;
              key_code    <= encode_key(cand);
              key_pressed <= 1'b1;
            end else if (snapshot == cand) begin
              cnt <= cnt_inc;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (snap_empty) begin
              state <= REL;
              cnt   <= CNT_ONE;
            end
          end
          REL: begin
            if (!snap_empty) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt_inc == CNT_LAST) begin
              state       <= IDLE;
              cnt         <= '0;
              key_pressed <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan_4x4.sv
// Self-checking bench for key_scan_4x4: a keypad matrix model driven scan by scan, checked
// against a scan-level reference of the debounce rules (repeat rules when KEY_SCAN_REPEAT_EN).
module tb_key_scan_4x4;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;
  localparam int RD       = 4;
  localparam int RP       = 2;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic       clk_24m = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  // Held keys indexed by code (row*4+col).
  logic [15:0] held = '0;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int now      = 0;
  int scan_no  = 0;
  int mark     = 0;
  bit prev_v   = 1'b0;
  bit prev_p   = 1'b0;

  bit          m_pressed;
  logic [3:0]  m_code;
  logic [15:0] m_cand;
  int          m_run;
  int          m_held;
  int          m_empty;

  logic [15:0] plan[$];

  key_scan_4x4 #(
    .SCAN_DIV      (SCAN_DIV),
    .DEB_SCANS     (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk_24m     (clk_24m),
    .rst_n       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  always #5 clk_24m = ~clk_24m;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = '1;
    for (int r = 0; r < 4; r++) key_row[r] = ~|(held[r*4 +: 4] & ~key_col);
  end

  always @(negedge clk_24m) if (key_valid === 1'b1) n_valid++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (scan %0d)", tag, obs, exp, scan_no);
    end
  endtask

  task automatic step_to(input int target);
    repeat (target - now) @(posedge clk_24m);
    now = target;
    #1;
  endtask

  task automatic model_reset();
    m_pressed = 1'b0;
    m_code    = '0;
    m_cand    = '0;
    m_run     = 0;
    m_held    = 0;
    m_empty   = 0;
  endtask

  // One full scan of the debounce rules, seen as a snapshot in code space.
  task automatic model_scan(input logic [15:0] s, output bit v);
    v = 1'b0;
    if (!m_pressed) begin
      if (m_run > 0 && s == m_cand) begin
        m_run++;
        if (m_run == DEB) begin
          v = 1'b1;
          m_pressed = 1'b1;
          for (int i = 0; i < 16; i++) if (m_cand[i]) m_code = 4'(i);
          m_run = 0;
          m_held = 0;
          m_empty = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
      end else if ($countones(s) == 1) begin
        m_cand = s;
        m_run = 1;
      end
    end else begin
      m_held++;
      if (s == '0) begin
        m_empty++;
        if (m_empty == DEB) begin
          m_pressed = 1'b0;
          m_held = 0;
          m_empty = 0;
        end
      end else begin
`ifdef KEY_SCAN_REPEAT_EN
        if (m_empty == 0 && m_held >= RD && (m_held - RD) % RP == 0) v = 1'b1;
`endif
        m_empty = 0;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] pat, input int n);
    repeat (n) plan.push_back(pat);
  endtask

  task automatic run_plan(input bit col_check);
    bit v;
    while (plan.size() > 0) begin
      scan_no++;
      held = plan.pop_front();
      model_scan(held, v);
      if (col_check && scan_no == 1) begin
        step_to(4);  check_output("col0", 32'(key_col), 32'(4'b1110));
        step_to(12); check_output("col1", 32'(key_col), 32'(4'b1101));
        step_to(20); check_output("col2", 32'(key_col), 32'(4'b1011));
        step_to(28); check_output("col3", 32'(key_col), 32'(4'b0111));
      end
      step_to(SCAN * scan_no);
      check_output("pressed_before_edge", 32'(key_pressed), 32'(prev_p));
      check_output("pulse_count", 32'(n_valid - mark), 32'(prev_v));
      mark = n_valid;
      step_to(SCAN * scan_no + 1);
      check_output("valid", 32'(key_valid), 32'(v));
      check_output("code", 32'(key_code), 32'(m_code));
      check_output("pressed", 32'(key_pressed), 32'(m_pressed));
      prev_v = v;
      prev_p = m_pressed;
    end
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk_24m);
    @(negedge clk_24m);
    rst_n   = 1'b1;
    now     = 0;
    scan_no = 0;
    mark    = n_valid;
    prev_v  = 1'b0;
    prev_p  = 1'b0;
  endtask

  initial begin
    int a;
    int b;
    int kind;
    model_reset();
    #2;
    check_output("rst_col", 32'(key_col), 32'(4'b1110));
    check_output("rst_code", 32'(key_code), 32'h0);
    check_output("rst_valid", 32'(key_valid), 32'h0);
    check_output("rst_pressed", 32'(key_pressed), 32'h0);
    release_reset();

    apply_stimulus(16'h0000, 2);
    apply_stimulus(16'h0200, 5);
    apply_stimulus(16'h0000, 4);
    apply_stimulus(16'h0200, 2);
    apply_stimulus(16'h0000, 3);
    apply_stimulus(16'h0201, 3);
    apply_stimulus(16'h0200, 4);
    apply_stimulus(16'h0000, 4);
    apply_stimulus(16'h0020, 4);
    apply_stimulus(16'h0000, 1);
    apply_stimulus(16'h0020, 2);
    apply_stimulus(16'h0000, 4);
    apply_stimulus(16'h8000, 14);
    apply_stimulus(16'h0000, 4);
    for (int i = 0; i < 25; i++) begin
      kind = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 15));
      b = (a + int'($urandom_range(1, 15))) % 16;
      case (kind)
        0:       apply_stimulus(16'h0000, int'($urandom_range(1, 5)));
        1:       apply_stimulus(16'(1) << a, int'($urandom_range(1, 6)));
        default: apply_stimulus((16'(1) << a) | (16'(1) << b), int'($urandom_range(1, 4)));
      endcase
    end
    apply_stimulus(16'h0000, 4);
    run_plan(1'b1);

    apply_stimulus(16'h8000, 4);
    run_plan(1'b0);
    step_to(now + 13);
    rst_n = 1'b0;
    #1;
    check_output("midrst_col", 32'(key_col), 32'(4'b1110));
    check_output("midrst_code", 32'(key_code), 32'h0);
    check_output("midrst_valid", 32'(key_valid), 32'h0);
    check_output("midrst_pressed", 32'(key_pressed), 32'h0);
    held = '0;
    model_reset();
    release_reset();

    apply_stimulus(16'h0000, 1);
    apply_stimulus(16'h0008, 4);
    apply_stimulus(16'h0000, 4);
    run_plan(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
